// File: rtl/ram_bist_ctrl.sv
// ram_bist_ctrl: built-in self-test sequencer for a single-port synchronous RAM.
// Two passes: write every address with P(a) = a ^ SEED (pass 0) or ~P(a)
// (pass 1), then read it all back and compare. The RAM read is registered, so
// the expected word is delayed one cycle to line up with mem_rdata.
//
// Ports:
//   clk, rst_n       clock (rising edge), asynchronous active-low reset
//   start            single-cycle request, honoured only in IDLE
//   mem_we/addr/wdata RAM write enable, address and write data
//   mem_rdata        RAM registered read data
//   busy             high while a test is running
//   done             one-cycle pulse when the test finishes
//   pass             err_count == 0, valid from done onward
//   err_count        mismatches over both passes
//   first_err_addr   address of the first mismatch (0 if none)
module ram_bist_ctrl #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8,
  parameter logic [DATA_W-1:0] SEED = 8'hA5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ADDR_W+1:0] err_count,
  output logic [ADDR_W-1:0] first_err_addr
);

  localparam int EW = ADDR_W + 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t              state, state_n;
  logic                pb, pb_n;
  logic                cmp_valid, cmp_valid_n;
  logic [DATA_W-1:0]   exp_data, exp_data_n;
  logic [ADDR_W-1:0]   cmp_addr, cmp_addr_n;
  logic                we_n;
  logic [ADDR_W-1:0]   addr_n;
  logic [DATA_W-1:0]   wdata_n;
  logic                busy_n, done_n, pass_n;
  logic [EW-1:0]       err_n;
  logic [ADDR_W-1:0]   fea_n;

  function automatic logic [DATA_W-1:0] pattern(input logic [ADDR_W-1:0] a,
                                                input logic inv);
    logic [DATA_W-1:0] p;
    p = DATA_W'(a) ^ SEED;
    return inv ? ~p : p;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      pb             <= 1'b0;
      cmp_valid      <= 1'b0;
      exp_data       <= '0;
      cmp_addr       <= '0;
      mem_we         <= 1'b0;
      mem_addr       <= '0;
      mem_wdata      <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      err_count      <= '0;
      first_err_addr <= '0;
    end else begin
      state          <= state_n;
      pb             <= pb_n;
      cmp_valid      <= cmp_valid_n;
      exp_data       <= exp_data_n;
      cmp_addr       <= cmp_addr_n;
      mem_we         <= we_n;
      mem_addr       <= addr_n;
      mem_wdata      <= wdata_n;
      busy           <= busy_n;
      done           <= done_n;
      pass           <= pass_n;
      err_count      <= err_n;
      first_err_addr <= fea_n;
    end
  end

  always_comb begin
    state_n     = state;
    pb_n        = pb;
    cmp_valid_n = 1'b0;
    exp_data_n  = exp_data;
    cmp_addr_n  = cmp_addr;
    we_n        = 1'b0;
    addr_n      = mem_addr;
    err_n       = err_count;
    fea_n       = first_err_addr;
    pass_n      = pass;

    // Aligned compare of the word requested one cycle earlier. err_count is
    // zeroed at start, so a zero count marks the first error of this test.
    if (cmp_valid && (mem_rdata != exp_data)) begin
      err_n = err_count + EW'(1);
      if (err_count == '0) fea_n = cmp_addr;
    end

    unique case (state)
      S_IDLE: begin
        if (start) begin
          state_n = S_WRITE;
          addr_n  = '0;
          we_n    = 1'b1;
          pb_n    = 1'b0;
          err_n   = '0;
          fea_n   = '0;
          pass_n  = 1'b0;
        end
      end
      S_WRITE: begin
        if (mem_addr == '1) begin
          state_n = S_READ;
          addr_n  = '0;
        end else begin
          addr_n = mem_addr + ADDR_W'(1);
          we_n   = 1'b1;
        end
      end
      S_READ: begin
        cmp_valid_n = 1'b1;
        exp_data_n  = pattern(mem_addr, pb);
        cmp_addr_n  = mem_addr;
        if (mem_addr == '1) state_n = S_DRAIN;
        else                addr_n  = mem_addr + ADDR_W'(1);
      end
      S_DRAIN: begin
        if (!pb) begin
          pb_n    = 1'b1;
          state_n = S_WRITE;
          addr_n  = '0;
          we_n    = 1'b1;
        end else begin
          state_n = S_DONE;
        end
      end
      S_DONE: begin
        pass_n  = (err_count == '0);
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase

    wdata_n = we_n ? pattern(addr_n, pb_n) : mem_wdata;
    // busy and done are registered from the state, so they trail it by a cycle.
    busy_n  = (state == S_WRITE) || (state == S_READ) || (state == S_DRAIN);
    done_n  = (state == S_DONE);
  end

endmodule
